// File: rtl/ltc2308_responder_pkg.sv
// ltc2308_pkg: shared types and config-word helpers for the LTC2308 responder
package ltc2308_pkg;
    typedef enum logic [1:0] {IDLE, CONVERT, WAIT, SHIFT} state_t;
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;
    localparam logic [5:0] CFG_DEFAULT = 6'b100010;
    function automatic logic [2:0] cfg_to_ch(input logic [5:0] cfg);
        return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
    endfunction
endpackage

// File: rtl/ltc2308_responder_if.sv
// ltc2308_responder_if: 4-wire ADC pin bundle (controller is master, emulated ADC is slave)
interface ltc2308_responder_if;
    logic adc_cs_n;
    logic adc_sclk;
    logic adc_din;
    logic adc_dout;
    modport master (output adc_cs_n, adc_sclk, adc_din, input adc_dout);
    modport slave (input adc_cs_n, adc_sclk, adc_din, output adc_dout);
endinterface

// File: rtl/ltc2308_responder_sync_edge_det.sv
// sync_edge_det: multi-stage synchronizer with registered level and rise/fall pulses
module sync_edge_det #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= {STAGES{INIT}};
            q    <= INIT;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= STAGES'({sync, d});
            q    <= sync[STAGES-1];
            rise <= sync[STAGES-1] & ~q;
            fall <= ~sync[STAGES-1] & q;
        end
    end
endmodule

// File: rtl/ltc2308_responder.sv
// ltc2308_responder: emulates the ADC end of an LTC2308 link (convert, then shift result out / config in)
module ltc2308_responder
    import ltc2308_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int CFG_W       = 6,
    parameter int CONV_CYCLES = 80,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    ltc2308_responder_if.slave  adc,
    output logic [2:0]          samp_ch,
    input  logic [DATA_W-1:0]   samp_data,
    output logic                busy,
    output logic [CFG_W-1:0]    cfg_word,
    output logic                cfg_update,
    output logic                frame_err
);
    localparam int CONV_W = $clog2(CONV_CYCLES);
    localparam int IN_W   = $clog2(CFG_W + 1);
    localparam int OUT_W  = $clog2(DATA_W + 1);

    state_t            state, state_d;
    logic [CONV_W-1:0] conv_cnt, conv_cnt_d;
    logic [DATA_W-1:0] out_sr, out_sr_d;
    logic [CFG_W-1:0]  cfg_shift, cfg_shift_d, cfg_word_d;
    logic [IN_W-1:0]   in_cnt, in_cnt_d;
    logic [OUT_W-1:0]  out_cnt, out_cnt_d;
    logic              dout, dout_d, cfg_update_d, frame_err_d;
    logic              cs_q, cs_rise, sclk_rise, sclk_fall, din_q;
    logic [3:0]        unused_edges;

    // CONVST idles high, so its synchronizer resets high to avoid a phantom rise
    sync_edge_det #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
        .clk(clk), .reset(reset), .d(adc.adc_cs_n),
        .q(cs_q), .rise(cs_rise), .fall(unused_edges[0])
    );
    sync_edge_det #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .d(adc.adc_sclk),
        .q(unused_edges[1]), .rise(sclk_rise), .fall(sclk_fall)
    );
    sync_edge_det #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_din (
        .clk(clk), .reset(reset), .d(adc.adc_din),
        .q(din_q), .rise(unused_edges[2]), .fall(unused_edges[3])
    );

    assign adc.adc_dout = dout;
    assign busy         = (state == CONVERT);
    assign samp_ch      = cfg_to_ch(cfg_word);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            conv_cnt   <= '0;
            out_sr     <= '0;
            cfg_shift  <= '0;
            cfg_word   <= CFG_DEFAULT;
            in_cnt     <= '0;
            out_cnt    <= '0;
            dout       <= 1'b0;
            cfg_update <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_d;
            conv_cnt   <= conv_cnt_d;
            out_sr     <= out_sr_d;
            cfg_shift  <= cfg_shift_d;
            cfg_word   <= cfg_word_d;
            in_cnt     <= in_cnt_d;
            out_cnt    <= out_cnt_d;
            dout       <= dout_d;
            cfg_update <= cfg_update_d;
            frame_err  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state;
        conv_cnt_d   = conv_cnt;
        out_sr_d     = out_sr;
        cfg_shift_d  = cfg_shift;
        cfg_word_d   = cfg_word;
        in_cnt_d     = in_cnt;
        out_cnt_d    = out_cnt;
        cfg_update_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_rise) begin
                    state_d    = CONVERT;
                    conv_cnt_d = '0;
                end
            end
            CONVERT: begin
                if (conv_cnt == CONV_W'(CONV_CYCLES - 1)) begin
                    state_d  = WAIT;
                    out_sr_d = cfg_word[CFG_UNI] ? samp_data
                                                 : samp_data ^ {1'b1, {(DATA_W-1){1'b0}}};
                end else begin
                    conv_cnt_d = conv_cnt + 1'b1;
                end
            end
            WAIT: begin
                if (!cs_q) state_d = SHIFT;
            end
            SHIFT: begin
                // frame end takes priority over any coincident SCLK edge
                if (cs_rise) begin
                    state_d      = CONVERT;
                    conv_cnt_d   = '0;
                    cfg_update_d = (in_cnt == IN_W'(CFG_W));
                    cfg_word_d   = cfg_update_d ? cfg_shift : cfg_word;
                    frame_err_d  = (out_cnt < OUT_W'(DATA_W));
                    in_cnt_d     = '0;
                    out_cnt_d    = '0;
                end else begin
                    if (sclk_rise && in_cnt < IN_W'(CFG_W)) begin
                        cfg_shift_d = {cfg_shift[CFG_W-2:0], din_q};
                        in_cnt_d    = in_cnt + 1'b1;
                    end
                    if (sclk_fall && out_cnt < OUT_W'(DATA_W)) begin
                        out_sr_d  = {out_sr[DATA_W-2:0], 1'b0};
                        out_cnt_d = out_cnt + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        dout_d = (state_d == WAIT || state_d == SHIFT) ? out_sr_d[DATA_W-1] : 1'b0;
    end
endmodule

// File: tb/tb_ltc2308_responder.sv
// tb_ltc2308_responder: random frames against a frame-level model of the ADC protocol
module tb_ltc2308_responder;
    import ltc2308_pkg::*;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] samp_data = '0;
    logic [2:0]  samp_ch;
    logic        busy, cfg_update, frame_err;
    logic [5:0]  cfg_word;

    ltc2308_responder_if adc();

    ltc2308_responder dut (
        .clk(clk), .reset(reset), .adc(adc), .samp_ch(samp_ch), .samp_data(samp_data),
        .busy(busy), .cfg_word(cfg_word), .cfg_update(cfg_update), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int n_upd = 0, n_err = 0;
    logic [5:0]  m_cfg;
    logic [11:0] m_res;
    int exp_upd, exp_err;

    always @(negedge clk) begin
        if (cfg_update) n_upd++;
        if (frame_err) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] ch_of(input logic [5:0] c);
        return {c[3], c[2], c[4]};
    endfunction

    // unipolar passes the code through; bipolar is code - 2048 modulo 4096
    function automatic logic [11:0] code_of(input logic [11:0] d, input logic [5:0] c);
        return c[1] ? d : 12'(d + 12'd2048);
    endfunction

    task automatic convert(input logic [11:0] d, input bit disturb);
        int t = 0, len = 0, u0 = n_upd, e0 = n_err;
        bit ch_ok = 1;
        samp_data = d;
        adc.adc_cs_n = 1'b1;
        while (!busy && t < 20) begin
            wait_clk(1);
            t++;
        end
        check("busy_latency", t, 4);
        fork
            begin
                while (busy && len < 200) begin
                    if (samp_ch !== ch_of(m_cfg)) ch_ok = 0;
                    wait_clk(1);
                    len++;
                end
            end
            if (disturb) begin
                wait_clk(5);
                repeat (3) begin
                    adc.adc_sclk = 1'b1; wait_clk(3);
                    adc.adc_sclk = 1'b0; wait_clk(3);
                end
                adc.adc_cs_n = 1'b0; wait_clk(4);
                adc.adc_cs_n = 1'b1;
            end
        join
        check("busy_len", len, 80);
        check("samp_ch", ch_ok, 1);
        check("cfg_update_cnt", n_upd - u0, exp_upd);
        check("frame_err_cnt", n_err - e0, exp_err);
        check("cfg_word", cfg_word, m_cfg);
        m_res = code_of(d, m_cfg);
    endtask

    task automatic frame(input int pulses, input logic [5:0] bits);
        logic [15:0] got = '0, exp = '0;
        adc.adc_cs_n = 1'b0;
        wait_clk(H);
        for (int i = 0; i < pulses; i++) begin
            adc.adc_din = (i < 6) ? bits[5-i] : 1'($urandom);
            wait_clk(H);
            got = {got[14:0], adc.adc_dout};
            exp = {exp[14:0], (i < 12) ? m_res[11-i] : 1'b0};
            adc.adc_sclk = 1'b1; wait_clk(H);
            adc.adc_sclk = 1'b0;
        end
        wait_clk(H);
        check("dout_bits", got, exp);
        if (pulses >= 6) m_cfg = bits;
        exp_upd = (pulses >= 6) ? 1 : 0;
        exp_err = (pulses < 12) ? 1 : 0;
    endtask

    initial begin
        int u0;
        adc.adc_cs_n = 1'b1;
        adc.adc_sclk = 1'b0;
        adc.adc_din  = 1'b0;
        wait_clk(5);
        check("rst_dout", adc.adc_dout, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_word", cfg_word, 6'b100010);
        check("rst_samp_ch", samp_ch, 0);
        check("rst_cfg_update", cfg_update, 0);
        check("rst_frame_err", frame_err, 0);
        reset = 1'b0;
        adc.adc_cs_n = 1'b0;
        wait_clk(H);
        m_cfg = 6'b100010; exp_upd = 0; exp_err = 0;
        convert(12'hA5C, 0);
        frame(12, 6'b111010);
        convert(12'(($urandom)), 0);
        frame(12, 6'b111000);
        convert(12'h000, 0);
        frame(12, 6'b111000);
        convert(12'hFFF, 0);
        frame(4, 6'b010110);
        convert(12'h3C5, 0);
        frame(7, 6'b100110);
        convert(12'h6B2, 1);
        frame(14, 6'b101010);
        for (int k = 0; k < 24; k++) begin
            convert(12'($urandom), k % 3 == 0);
            frame($urandom_range(0, 14), 6'($urandom));
        end
        convert(12'h5A5, 0);
        adc.adc_cs_n = 1'b0;
        wait_clk(H);
        for (int i = 0; i < 5; i++) begin
            adc.adc_din = 1'b1; wait_clk(H);
            adc.adc_sclk = 1'b1; wait_clk(H);
            adc.adc_sclk = 1'b0;
        end
        wait_clk(2);
        u0 = n_upd;
        reset = 1'b1;
        wait_clk(1);
        check("mid_rst_dout", adc.adc_dout, 0);
        check("mid_rst_cfg_word", cfg_word, 6'b100010);
        check("mid_rst_busy", busy, 0);
        reset = 1'b0;
        wait_clk(H);
        check("mid_rst_no_update", n_upd - u0, 0);
        check("mid_rst_samp_ch", samp_ch, 0);
        m_cfg = 6'b100010; exp_upd = 0; exp_err = 0;
        convert(12'h9E1, 0);
        frame(12, 6'b100010);
        convert(12'h123, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
